uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Serial-to-parallel UART receiver: the receive-side counterpart of the team's `uart_tx`. It converts the asynchronous `rxd` line into 8-bit bytes and presents each byte on a valid/ready handshake to the downstream consumer, such as the scan/debug logic. The frame format is 8N1, LSB first, with mid-bit sampling from a clocks-per-bit counter. Framing errors and overflow are reported as one-cycle pulses.

## Interface
Parameters:
- `DIV`, default 868: `clk` cycles per bit (100 MHz / 115200). Must be even and ≥ 4.

Ports:
- `clk`, input, 1: sole clock; all state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rxd`, input, 1: serial line, idle high, asynchronous to `clk`.
- `d_rx`, output, 8: received byte; stable while `vld_rx` is high.
- `vld_rx`, output, 1: byte available.
- `rdy_rx`, input, 1: consumer accepts the byte.
- `ferr`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `ovr`, output, 1: one-cycle pulse when a good frame is dropped because the buffer is full.

## Operation
- Synchronizer:
  - `rxd` passes through a 2-flop synchronizer to produce `rxd_s`.
  - Both flops reset to 1, so reset never produces a false start.
- Bit counter `cnt`: `$clog2(DIV)` bits, cleared on every state entry.
- Bit index `idx`: 3 bits.
- Shift register `sh`: 8 bits, shifts right with the sampled bit entering at MSB, so the byte is LSB-first.
- FSM states:
  - IDLE: `rxd_s==0` → START.
  - START: at `cnt==DIV/2-1`, sample `rxd_s`. If 1 (glitch) → IDLE. If 0 → DATA with `idx=0`.
  - DATA: at `cnt==DIV-1`, shift in `rxd_s`. If `idx==7` → STOP; otherwise `idx++`.
  - STOP: at `cnt==DIV-1`, sample `rxd_s`.
    - 1: deliver the byte (see buffer rules) → IDLE.
    - 0: pulse `ferr`, discard the byte → WAIT_HIGH.
  - WAIT_HIGH: stay until `rxd_s==1` → IDLE. This covers a break condition and prevents a false start.
- Output buffer: one entry, made up of `d_rx` and `vld_rx`.
  - Delivery when the buffer is empty, or is being consumed this cycle (`vld_rx & rdy_rx`): load `d_rx ← sh`, set `vld_rx=1`.
  - Delivery while `vld_rx=1 & rdy_rx=0`: pulse `ovr`. The new byte is dropped; the old `d_rx`/`vld_rx` are kept.
  - Transfer occurs on any edge where `vld_rx & rdy_rx`. `vld_rx` clears the next cycle unless a simultaneous delivery reloads it.
- `vld_rx` never depends combinationally on `rdy_rx`.
- `rdy_rx` may be held high continuously.

## Timing
- Reset values: `d_rx=8'h00`, `vld_rx=0`, `ferr=0`, `ovr=0`. Internal state: IDLE, `cnt=0`, `idx=0`, `sh=0`.
- Reset takes effect immediately, including mid-frame. Recovery is a clean IDLE; the next falling edge begins a new frame.
- Pin to `rxd_s`: 2 cycles.
- Let T0 be the IDLE cycle in which `rxd_s==0`. Then:
  - Start sample: T0+DIV/2.
  - Bit k sample: T0+DIV/2+(k+1)·DIV.
  - Stop sample: T0+DIV/2+9·DIV.
  - `vld_rx`, `ferr` or `ovr` registered high at T0+DIV/2+9·DIV+1.
- IDLE is re-entered the cycle after the stop sample. Back-to-back frames with zero idle time are received without loss.
- `ferr`/`ovr` are high for exactly one cycle and are mutually exclusive.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE, START, DATA, STOP, WAIT_HIGH.
  - `DATA_BITS=8`.
  - Default `DIV`.
  - `uart_tx` uses the same constants.
- One sub-module, `uart_sync`:
  - 2-flop synchronizer with parameterized reset value 1.
  - Reused later for other asynchronous inputs.
- Counter, FSM and buffer live in `uart_rx_core`. Estimated 150–250 lines of RTL.

## Test plan
All scenarios use `DIV=16` and drive `rxd` from a bit-accurate bench model.
1. Frame 0x55 with `rdy_rx=1` → `vld_rx` high at T0+153 for exactly one cycle, `d_rx=0x55`, no `ferr`/`ovr`.
2. `rxd` low for 4 cycles, then high → no `vld_rx`/`ferr`; the FSM returns to IDLE. A following 0x3C frame is received correctly.
3. Frame 0xA3 with stop bit 0, `rxd` held low 48 more cycles, then high → single `ferr` pulse, no `vld_rx`, no restart while low. A following 0x0F frame is received.
4. Back-to-back 0x12 and 0x34 with `rdy_rx=0` → `vld_rx=1` with `d_rx=0x12`. `ovr` pulses at the second delivery; `d_rx` stays 0x12.
5. Same frames, `rdy_rx` pulsed high exactly in the second delivery cycle → 0x12 transferred, `d_rx=0x34`, `vld_rx` uninterrupted, no `ovr`.
6. `rst` asserted during DATA bit 4 → outputs zero asynchronously. After release, frame 0xC6 is received correctly with no spurious `ferr`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and receiver FSM encoding.
// uart_tx uses the same frame constants.
package uart_pkg;

  localparam int DATA_BITS   = 8;
  localparam int DIV_DEFAULT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is chosen so that reset never looks like an input event.
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments keep the two stages as distinct flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready buffer.
// Framing errors and dropped frames are reported as one-cycle pulses.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] d_rx,
  output logic                 vld_rx,
  input  logic                 rdy_rx,
  output logic                 ferr,
  output logic                 ovr
);

  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(DATA_BITS);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t HALF_END = cnt_t'(DIV / 2 - 1);
  localparam cnt_t BIT_END  = cnt_t'(DIV - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 rxd_s;
  rx_state_t            state, state_nxt;
  cnt_t                 cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] sh, sh_nxt;
  logic                 deliver, frame_err;

  uart_sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      sh    <= sh_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    idx_nxt   = idx;
    sh_nxt    = sh;
    deliver   = 1'b0;
    frame_err = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rxd_s) state_nxt = START;
      end
      START: begin
        if (cnt == HALF_END) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            state_nxt = IDLE;  // start bit gone by mid-bit: glitch
          end else begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end
        end
      end
      DATA: begin
        if (cnt == BIT_END) begin
          cnt_nxt = '0;
          sh_nxt  = {rxd_s, sh[DATA_BITS-1:1]};
          if (idx == LAST_IDX) state_nxt = STOP;
          else                 idx_nxt   = idx + 1'b1;
        end
      end
      STOP: begin
        if (cnt == BIT_END) begin
          cnt_nxt   = '0;
          deliver   = rxd_s;
          frame_err = !rxd_s;
          state_nxt = rxd_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rxd_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A delivery may refill the buffer in the same cycle it is being drained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_rx   <= '0;
      vld_rx <= 1'b0;
      ferr   <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      ferr <= frame_err;
      ovr  <= 1'b0;
      if (vld_rx && rdy_rx) vld_rx <= 1'b0;
      if (deliver) begin
        if (!vld_rx || rdy_rx) begin
          d_rx   <= sh;
          vld_rx <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized scoreboard bench for uart_rx_core at DIV=16: the driver predicts
// each frame's outcome and arrival cycle, a monitor compares DUT events in order.
module tb_uart_rx_core;

  localparam int DIV = 16;
  // pin -> rxd_s (2) + IDLE detect (1) + start half bit + 8 data + stop bit
  localparam int LAT = 3 + DIV / 2 + 9 * DIV;

  typedef enum logic [1:0] {EV_BYTE, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rdy_rx = 1'b1;
  logic [7:0] d_rx;
  logic       vld_rx, ferr, ovr;

  int  cyc = 0;
  int  checks = 0;
  int  passes = 0;
  ev_t exp_q[$];

  uart_rx_core #(.DIV(DIV)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .d_rx   (d_rx),
    .vld_rx (vld_rx),
    .rdy_rx (rdy_rx),
    .ferr   (ferr),
    .ovr    (ovr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_ev(input ev_kind_t kind, input logic [7:0] data);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_event: got %s, expected none (cycle %0d)", kind.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      check("event_cycle", cyc, e.cyc);
      if (e.kind == EV_BYTE) check("byte_data", 32'(data), 32'(e.data));
    end
  endtask

  // Monitor: one look per cycle, just after the active edge.
  logic       vld_q = 1'b0;
  logic       hs;
  logic [7:0] d_q = '0;
  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      vld_q = 1'b0;
    end else begin
      hs = vld_q && rdy_rx;
      if (ferr) expect_ev(EV_FERR, 8'h00);
      if (ovr)  expect_ev(EV_OVR, 8'h00);
      if (vld_rx && (!vld_q || hs)) expect_ev(EV_BYTE, d_rx);
      if (vld_q && !hs) begin
        check("hold_vld", 32'(vld_rx), 32'd1);
        check("hold_data", 32'(d_rx), 32'(d_q));
      end
      vld_q = vld_rx;
      d_q   = d_rx;
    end
  end

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (DIV) @(negedge clk);
  endtask

  // Reference model: a good frame yields its byte unless the buffer is known busy.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic buf_busy);
    ev_t e;
    e.cyc  = cyc + LAT;
    e.data = data;
    e.kind = !stop_bit ? EV_FERR : (buf_busy ? EV_OVR : EV_BYTE);
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(data[i]);
    drive_bit(stop_bit);
  endtask

  int         k2;
  logic [7:0] rnd_byte;
  logic       rnd_bad;
  logic [7:0] c6;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_d_rx", 32'(d_rx), 32'h00);
    check("reset_vld_rx", 32'(vld_rx), 32'd0);
    check("reset_ferr", 32'(ferr), 32'd0);
    check("reset_ovr", 32'(ovr), 32'd0);
    rst = 1'b0;
    idle(5);

    // Single frame, consumer always ready.
    send_frame(8'h55, 1'b1, 1'b0);
    idle(10);

    // Short low glitch, then a real frame.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * DIV);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(10);

    // Framing error followed by a long break.
    send_frame(8'hA3, 1'b0, 1'b0);
    repeat (48) @(negedge clk);
    idle(2 * DIV);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(10);

    // Back-to-back frames into a stalled consumer: second one overflows.
    rdy_rx = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(10);
    check("ovr_keeps_data", 32'(d_rx), 32'h12);
    check("ovr_keeps_vld", 32'(vld_rx), 32'd1);
    rdy_rx = 1'b1;
    @(negedge clk);
    rdy_rx = 1'b0;
    idle(5);
    check("drained_vld", 32'(vld_rx), 32'd0);

    // Same frames, consumer accepts exactly in the second delivery cycle.
    send_frame(8'h12, 1'b1, 1'b0);
    k2 = cyc;
    fork
      send_frame(8'h34, 1'b1, 1'b0);
      begin
        while (cyc != k2 + LAT - 1) @(negedge clk);
        rdy_rx = 1'b1;
        @(negedge clk);
        rdy_rx = 1'b0;
      end
    join
    idle(10);
    check("reload_data", 32'(d_rx), 32'h34);
    check("reload_vld", 32'(vld_rx), 32'd1);
    rdy_rx = 1'b1;
    idle(10);

    // Randomized traffic with occasional framing errors.
    for (int n = 0; n < 24; n++) begin
      rnd_byte = 8'($urandom);
      rnd_bad  = ($urandom_range(0, 5) == 0);
      send_frame(rnd_byte, !rnd_bad, 1'b0);
      if (rnd_bad) begin
        repeat ($urandom_range(0, 40)) @(negedge clk);
        idle(DIV);
      end else begin
        idle($urandom_range(0, 12));
      end
    end
    idle(10);

    // Reset in the middle of data bit 4 while a byte is buffered.
    rdy_rx = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    c6 = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(c6[i]);
    rxd = c6[4];
    repeat (DIV / 2) @(negedge clk);
    #2;
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    check("async_rst_vld", 32'(vld_rx), 32'd0);
    check("async_rst_d_rx", 32'(d_rx), 32'h00);
    check("async_rst_ferr", 32'(ferr), 32'd0);
    check("async_rst_ovr", 32'(ovr), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    rdy_rx = 1'b1;
    idle(2 * DIV);
    send_frame(8'hC6, 1'b1, 1'b0);
    idle(10);

    for (int t = 0; t < 500 && exp_q.size() != 0; t++) @(negedge clk);
    check("events_all_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
